// File: rtl/sbp_lookup_stage_wide.sv
// One level of a pipelined longest-prefix-match trie with a parametrised key width.
// Owns its stage memory, clears it with an init/flush sweep, and keeps hit/miss statistics.
module sbp_lookup_stage_wide #(
   parameter int unsigned STAGE_ID      = 1,
   parameter int unsigned STAGE_ID_BITS = 6,
   parameter int unsigned LOCATION_BITS = 11,
   parameter int unsigned KEY_BITS      = 32,
   parameter int unsigned CNT_BITS      = 32,
   localparam int unsigned POS_BITS     = $clog2(KEY_BITS) + 1,
   localparam int unsigned RESULT_BITS  = 1 + STAGE_ID_BITS + LOCATION_BITS,
   localparam int unsigned MEM_BITS     = 1 + KEY_BITS + POS_BITS + STAGE_ID_BITS + LOCATION_BITS + 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     valid_i,
   input  logic                     update_i,
   input  logic [KEY_BITS-1:0]      key_i,
   input  logic [POS_BITS-1:0]      bit_pos_i,
   input  logic [STAGE_ID_BITS-1:0] stage_id_i,
   input  logic [LOCATION_BITS-1:0] location_i,
   input  logic [RESULT_BITS-1:0]   result_i,
   input  logic [MEM_BITS-1:0]      upd_data_i,
   input  logic                     flush_i,
   input  logic                     cnt_clr_i,
   output logic                     valid_o,
   output logic                     update_o,
   output logic [KEY_BITS-1:0]      key_o,
   output logic [POS_BITS-1:0]      bit_pos_o,
   output logic [STAGE_ID_BITS-1:0] stage_id_o,
   output logic [LOCATION_BITS-1:0] location_o,
   output logic [RESULT_BITS-1:0]   result_o,
   output logic [MEM_BITS-1:0]      upd_data_o,
   output logic                     ready_o,
   output logic                     err_o,
   output logic [CNT_BITS-1:0]      hit_cnt_o,
   output logic [CNT_BITS-1:0]      miss_cnt_o
);

   localparam int unsigned DEPTH = 2 ** LOCATION_BITS;
   localparam logic [STAGE_ID_BITS-1:0] SID     = STAGE_ID_BITS'(STAGE_ID);
   localparam logic [POS_BITS-1:0]      KEY_POS = POS_BITS'(KEY_BITS);
   localparam logic [KEY_BITS-1:0]      ONES    = '1;

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   state_t                   state_q, state_d;
   logic [LOCATION_BITS-1:0] ptr_q, ptr_d;

   logic                     sel;
   logic                     mem_we;
   logic [LOCATION_BITS-1:0] mem_wa;
   logic [MEM_BITS-1:0]      mem_wd;
   logic [MEM_BITS-1:0]      mem [DEPTH];
   logic [MEM_BITS-1:0]      mem_rd;

   logic                     s0_valid, s0_update, s0_lkp;
   logic [KEY_BITS-1:0]      s0_key;
   logic [POS_BITS-1:0]      s0_bit_pos;
   logic [STAGE_ID_BITS-1:0] s0_stage_id;
   logic [LOCATION_BITS-1:0] s0_location;
   logic [RESULT_BITS-1:0]   s0_result;
   logic [MEM_BITS-1:0]      s0_upd_data;

   logic                     e_valid, e_has_left, e_has_right;
   logic [KEY_BITS-1:0]      e_prefix;
   logic [POS_BITS-1:0]      e_len;
   logic [STAGE_ID_BITS-1:0] e_child_stage;
   logic [LOCATION_BITS-1:0] e_child_loc;

   logic [KEY_BITS-1:0]      match_mask, key_shl;
   logic                     key_match, right_sel, has_child;
   logic [POS_BITS-1:0]      pos_next;

   // ---------------- init/flush sweep FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_INIT;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      if (flush_i) begin
         state_d = ST_INIT;
         ptr_d   = '0;
      end else if (state_q == ST_INIT) begin
         ptr_d = ptr_q + LOCATION_BITS'(1);
         if (ptr_q == '1) state_d = ST_RUN;
      end
   end

   assign ready_o = (state_q == ST_RUN);
   assign sel     = valid_i && (stage_id_i == SID);

   // Single write port: the sweep owns it while not ready, so updates are simply dropped then.
   always_comb begin
      mem_we = 1'b0;
      mem_wa = location_i;
      mem_wd = upd_data_i;
      if (!ready_o) begin
         mem_we = 1'b1;
         mem_wa = ptr_q;
         mem_wd = '0;
      end else if (sel && update_i) begin
         mem_we = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_wa] <= mem_wd;
      mem_rd <= mem[location_i];
   end

   // ---------------- stage 0: register inputs ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s0_valid    <= 1'b0;
         s0_update   <= 1'b0;
         s0_lkp      <= 1'b0;
         s0_key      <= '0;
         s0_bit_pos  <= '0;
         s0_stage_id <= '0;
         s0_location <= '0;
         s0_result   <= '0;
         s0_upd_data <= '0;
         err_o       <= 1'b0;
      end else begin
         s0_valid    <= valid_i;
         s0_update   <= update_i;
         s0_lkp      <= sel && !update_i && ready_o;
         s0_key      <= key_i;
         s0_bit_pos  <= bit_pos_i;
         s0_stage_id <= stage_id_i;
         s0_location <= location_i;
         s0_result   <= result_i;
         s0_upd_data <= upd_data_i;
         if (sel && !ready_o) err_o <= 1'b1;
      end
   end

   // ---------------- stage 1: evaluate entry ----------------
   assign {e_valid, e_prefix, e_len, e_child_stage, e_child_loc, e_has_left, e_has_right} = mem_rd;

   // Shifting by >= KEY_BITS yields zero, so len 0 masks nothing and len >= KEY_BITS masks all.
   assign match_mask = ~(ONES >> e_len);
   assign key_match  = e_valid && (((s0_key ^ e_prefix) & match_mask) == '0);
   assign key_shl    = s0_key << s0_bit_pos;
   assign right_sel  = key_shl[KEY_BITS-1];
   assign has_child  = right_sel ? e_has_right : e_has_left;
   assign pos_next   = (s0_bit_pos >= KEY_POS) ? KEY_POS : s0_bit_pos + POS_BITS'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_o    <= 1'b0;
         update_o   <= 1'b0;
         key_o      <= '0;
         bit_pos_o  <= '0;
         stage_id_o <= '0;
         location_o <= '0;
         result_o   <= '0;
         upd_data_o <= '0;
      end else begin
         valid_o    <= s0_valid;
         update_o   <= s0_update;
         key_o      <= s0_key;
         upd_data_o <= s0_upd_data;
         if (s0_lkp) begin
            bit_pos_o  <= pos_next;
            stage_id_o <= has_child ? e_child_stage : '0;
            location_o <= e_child_loc + LOCATION_BITS'(right_sel);
            result_o   <= key_match ? {1'b1, SID, s0_location} : s0_result;
         end else begin
            bit_pos_o  <= s0_bit_pos;
            stage_id_o <= s0_stage_id;
            location_o <= s0_location;
            result_o   <= s0_result;
         end
      end
   end

   // ---------------- saturating statistics ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_cnt_o  <= '0;
         miss_cnt_o <= '0;
      end else if (cnt_clr_i) begin
         hit_cnt_o  <= '0;
         miss_cnt_o <= '0;
      end else if (s0_lkp) begin
         if (key_match) begin
            if (hit_cnt_o != '1) hit_cnt_o <= hit_cnt_o + CNT_BITS'(1);
         end else begin
            if (miss_cnt_o != '1) miss_cnt_o <= miss_cnt_o + CNT_BITS'(1);
         end
      end
   end

endmodule
